// File: rtl/radix4_serial_divider_pkg.sv
// Shared types for the radix-4 serial divider.
//   state_e   : controller states (IDLE, RUN, DONE)
//   digit_t   : one radix-4 quotient digit (0..3)
//   cnt_width : width of the iteration counter for a given operand width
package radix4_serial_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [1:0] digit_t;

    // The counter must hold WIDTH/2 itself, hence the +1.
    function automatic int cnt_width(input int width);
        return $clog2(width / 2) + 1;
    endfunction

endpackage

// File: rtl/radix4_digit_select.sv
// Combinational radix-4 digit selection and partial-remainder update.
// Picks the largest q in 0..3 with q*D <= R' and returns R' - q*D.
//   r_prime_i : shifted partial remainder {R, next two dividend bits}
//   d_i       : divisor D, zero-extended to WIDTH+2
//   d2_i      : 2D
//   d3_i      : 3D (precomputed and registered by the caller)
//   q_o       : selected quotient digit
//   r_new_o   : new partial remainder R' - q*D
module radix4_digit_select
    import radix4_serial_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] r_prime_i,
    input  logic [WIDTH+1:0] d_i,
    input  logic [WIDTH+1:0] d2_i,
    input  logic [WIDTH+1:0] d3_i,
    output digit_t           q_o,
    output logic [WIDTH+1:0] r_new_o
);

    always_comb begin
        q_o     = 2'd0;
        r_new_o = r_prime_i;
        if (r_prime_i >= d3_i) begin
            q_o     = 2'd3;
            r_new_o = r_prime_i - d3_i;
        end else if (r_prime_i >= d2_i) begin
            q_o     = 2'd2;
            r_new_o = r_prime_i - d2_i;
        end else if (r_prime_i >= d_i) begin
            q_o     = 2'd1;
            r_new_o = r_prime_i - d_i;
        end
    end

endmodule

// File: rtl/radix4_serial_divider.sv
// Unsigned radix-4 restoring divider, two quotient bits per clock.
// WIDTH must be even and >= 4.
//   clk, reset   : clock (rising edge), asynchronous active-high reset
//   start        : request a division; accepted in IDLE or DONE
//   dividend     : unsigned dividend, sampled on accept
//   divisor      : unsigned divisor, sampled on accept
//   busy         : high while iterating (RUN)
//   done         : one-cycle pulse when quotient/remainder become valid
//   quotient     : floor(dividend/divisor); all ones on divide-by-zero
//   remainder    : dividend mod divisor; dividend on divide-by-zero
//   div_by_zero  : last accepted divisor was zero
module radix4_serial_divider
    import radix4_serial_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             W2    = WIDTH + 2;
    localparam int             CW    = cnt_width(WIDTH);
    localparam logic [CW-1:0]  ITERS = CW'(WIDTH / 2);

    state_e            state_q;
    logic [WIDTH-1:0]  dvd_q;      // dividend shifts out the top, digits enter the bottom
    logic [W2-1:0]     d_q;
    logic [W2-1:0]     d3_q;
    logic [W2-1:0]     r_q;
    logic [CW-1:0]     cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              dbz_q;
    logic [WIDTH-1:0]  quo_q;
    logic [WIDTH-1:0]  rem_q;

    logic [W2-1:0]     r_prime_d;
    logic [W2-1:0]     d2_d;
    logic [W2-1:0]     r_d;
    digit_t            q_d;

    // R < D always holds, so shifting the full R left by two loses nothing.
    assign r_prime_d = (r_q << 2) | W2'(dvd_q[WIDTH-1 -: 2]);
    assign d2_d      = d_q << 1;

    radix4_digit_select #(.WIDTH(WIDTH)) u_sel (
        .r_prime_i (r_prime_d),
        .d_i       (d_q),
        .d2_i      (d2_d),
        .d3_i      (d3_q),
        .q_o       (q_d),
        .r_new_o   (r_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            d_q     <= '0;
            d3_q    <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        dvd_q <= dividend;
                        d_q   <= W2'(divisor);
                        d3_q  <= W2'(divisor) + (W2'(divisor) << 1);
                        r_q   <= '0;
                        cnt_q <= ITERS;
                        if (divisor == '0) begin
                            // No iterations: results are known at accept.
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            quo_q   <= '1;
                            rem_q   <= dividend;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            dbz_q   <= 1'b0;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    r_q   <= r_d;
                    dvd_q <= {dvd_q[WIDTH-3:0], q_d};
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quo_q   <= {dvd_q[WIDTH-3:0], q_d};
                        rem_q   <= r_d[WIDTH-1:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_radix4_serial_divider.sv
module tb_radix4_serial_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    radix4_serial_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Integer-division reference, including the divide-by-zero convention.
    task automatic model(input int a, input int b, output int q, output int r);
        if (b == 0) begin
            q = (1 << W) - 1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    function automatic int pick();
        int s;
        s = $urandom_range(0, 9);
        if (s == 0) return 0;
        if (s == 1) return (1 << W) - 1;
        if (s == 2) return 1;
        return int'($urandom_range(0, (1 << W) - 1));
    endfunction

    // Enter at a negedge; issue a request and follow it to done.
    // inj  : pulse a 9/9 start during RUN, which must be ignored
    // tail : afterwards check done is a single pulse and the block goes idle
    task automatic op(input int a, input int b, input bit inj, input bit tail);
        int  eq, er, lat, nbusy, exp_lat;
        bit  seen;
        model(a, b, eq, er);
        exp_lat  = (b == 0) ? 0 : W / 2;
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        chk("acc_busy", int'(busy), int'(b != 0));
        lat   = 0;
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inj && i == 1) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 8'd9;
            end else if (inj && i == 2) begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
            lat++;
        end
        chk("done_seen", int'(seen), 1);
        if (!seen) return;
        chk("latency", lat, exp_lat);
        chk("busy_cycles", nbusy, exp_lat);
        chk("quotient", int'(quotient), eq);
        chk("remainder", int'(remainder), er);
        chk("div_by_zero", int'(div_by_zero), int'(b == 0));
        if (tail) begin
            @(negedge clk);
            chk("done_pulse", int'(done), 0);
            chk("idle_busy", int'(busy), 0);
            chk("hold_quotient", int'(quotient), eq);
            chk("hold_remainder", int'(remainder), er);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        reset = 1'b0;
        @(negedge clk);

        op(100, 7, 1'b0, 1'b1);
        // Back-to-back: second start lands while in DONE.
        op(255, 1, 1'b0, 1'b0);
        op(3, 200, 1'b0, 1'b1);
        op(5, 0, 1'b0, 1'b1);
        op(200, 3, 1'b1, 1'b1);
        op(0, 37, 1'b0, 1'b1);
        op(255, 255, 1'b0, 1'b1);

        // Reset two cycles into RUN.
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_dbz", int'(div_by_zero), 0);
        chk("mid_rst_quotient", int'(quotient), 0);
        chk("mid_rst_remainder", int'(remainder), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_no_done", int'(done), 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", int'(done), 0);
        end
        op(9, 9, 1'b0, 1'b1);

        // Random sweep, chained through DONE.
        for (int n = 0; n < 10000; n++) begin
            op(pick(), pick(), 1'b0, n == 9999);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
